// File: rtl/psum_acc.sv
// psum_acc: two-group partial-sum accumulator for the conv output map.
// Group 0 beats for every map offset are parked in an on-chip buffer; the
// matching group 1 beats are then added to them and streamed to the omap writer
// through a two-stage (read, sum) pipeline with ready/valid flow control.
// Optional build macro: PSUM_ACC_SAT_EN selects a saturating sum instead of a
// wrapping two's-complement sum.
module psum_acc #(
    parameter int DATA_W   = 32,
    parameter int MAP_LAST = 3135
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [31:0]       in_info,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [12:0]       out_info,
    output logic              ch_done,
    output logic              all_done,
    output logic              seq_err
);

    localparam int         DEPTH    = MAP_LAST + 1;
    localparam int         AW       = (MAP_LAST < 1) ? 1 : $clog2(MAP_LAST + 1);
    localparam logic [11:0] LAST_OFF = 12'(MAP_LAST);

    typedef enum logic {
        G0 = 1'b0,
        G1 = 1'b1
    } state_t;

    state_t            state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic              s1_vld;
    logic [DATA_W-1:0] s1_data;
    logic [12:0]       s1_info;
    logic [5:0]        ch_cnt;

    logic              advance;
    logic              accept;
    logic              grp;
    logic [11:0]       off;
    logic [AW-1:0]     addr;
    logic              off_ok;
    logic              grp_ok;
    logic              beat_ok;
    logic              is_last;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] sum;
    logic              unused_info;

    // The whole pipeline moves together; the input is only ready when it moves.
    assign advance = !out_vld || out_rdy;
    assign in_rdy  = advance;
    assign accept  = in_vld && advance;

    assign grp     = in_info[12];
    assign off     = in_info[11:0];
    assign addr    = off[AW-1:0];
    assign off_ok  = (off <= LAST_OFF);
    assign grp_ok  = (grp == (state == G1));
    assign beat_ok = accept && off_ok && grp_ok;
    assign is_last = (off == LAST_OFF);
    assign wr_en   = beat_ok && (state == G0);
    assign rd_en   = beat_ok && (state == G1);

    // Upper info bits carry nothing this block uses.
    assign unused_info = ^in_info[31:14];

`ifdef PSUM_ACC_SAT_EN
    logic signed [DATA_W:0] wide;

    // Widen by one bit and clamp to the signed range when the sum overflows.
    always_comb begin
        wide = $signed({s1_data[DATA_W-1], s1_data}) + $signed({rd_data[DATA_W-1], rd_data});
        sum  = wide[DATA_W-1:0];
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sum = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign sum = s1_data + rd_data;
`endif

    // Group 0 store and registered group 1 read; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= in_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

    // Group FSM, read/sum pipeline, channel counter and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= G0;
            s1_vld   <= 1'b0;
            s1_data  <= '0;
            s1_info  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_info <= '0;
            ch_done  <= 1'b0;
            all_done <= 1'b0;
            seq_err  <= 1'b0;
            ch_cnt   <= '0;
        end else begin
            ch_done  <= 1'b0;
            all_done <= 1'b0;

            if (accept && !beat_ok) begin
                seq_err <= 1'b1;
            end

            if (advance) begin
                s1_vld  <= rd_en;
                s1_data <= in_data;
                s1_info <= {in_info[13], off};
                out_vld <= s1_vld;
                if (s1_vld) begin
                    out_data <= sum;
                    out_info <= s1_info;
                end
            end

            if (beat_ok && is_last) begin
                case (state)
                    G0: state <= G1;
                    G1: begin
                        state   <= G0;
                        ch_done <= 1'b1;
                        ch_cnt  <= ch_cnt + 6'd1;
                        if (ch_cnt == 6'd63) begin
                            all_done <= 1'b1;
                        end
                    end
                    default: state <= G0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: self-checking bench for psum_acc with a result scoreboard.
module tb_psum_acc;

    localparam int DATA_W = 32;
    localparam int LAST   = 127;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_vld   = 1'b0;
    logic        in_rdy;
    logic [31:0] in_info  = '0;
    logic [31:0] in_data  = '0;
    logic        out_vld;
    logic        out_rdy  = 1'b1;
    logic [31:0] out_data;
    logic [12:0] out_info;
    logic        ch_done;
    logic        all_done;
    logic        seq_err;

    psum_acc #(.DATA_W(DATA_W), .MAP_LAST(LAST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_info  (in_info),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_info (out_info),
        .ch_done  (ch_done),
        .all_done (all_done),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [12:0] info;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] gbuf  [0:LAST];
    logic [31:0] g1mem [0:LAST];
    logic        mstate      = 1'b0;
    bit          lat_en      = 1'b1;
    bit          fresh       = 1'b1;
    int          cyc         = 0;
    int          checks      = 0;
    int          passes      = 0;
    int          last_g1_acc = -10;
    int          ch_pulses   = 0;
    int          all_pulses  = 0;
    int          all_at      = 0;

    // Free-running cycle count used to time accepts against results.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] modelSum(input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] w;
        logic [31:0]        r;
        w = $signed({a[31], a}) + $signed({b[31], b});
        r = w[31:0];
`ifdef PSUM_ACC_SAT_EN
        if (w > 33'sd2147483647) r = 32'h7FFF_FFFF;
        if (w < -33'sd2147483648) r = 32'h8000_0000;
`endif
        return r;
    endfunction

    function automatic logic [31:0] g0Data(input int mode, input int o);
        if (mode == 0) return 32'(o);
        if (mode == 2 && o == 0) return 32'h7FFF_FFFF;
        if (mode == 2 && o == 1) return 32'h8000_0000;
        return $urandom();
    endfunction

    function automatic logic [31:0] g1Data(input int mode, input int o);
        if (mode == 0) return 32'd1;
        if (mode == 2 && o == 0) return 32'd1;
        if (mode == 2 && o == 1) return 32'hFFFF_FFFF;
        return $urandom();
    endfunction

    // Drive one beat until accepted and update the reference model on acceptance.
    task automatic applyStimulus(input logic grp, input logic half, input logic [11:0] off, input logic [31:0] data);
        int          waitc;
        bit          good;
        logic [17:0] junk;
        junk    = 18'($urandom());
        in_info = {junk, half, grp, off};
        in_data = data;
        in_vld  = 1'b1;
        waitc   = 0;
        @(negedge clk);
        while (!in_rdy && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_rdy) begin
            checkOutput("accept_timeout", in_rdy, 1);
        end else begin
            good = (int'(off) <= LAST) && (grp == mstate);
            if (good) begin
                if (!mstate) begin
                    gbuf[off] = data;
                end else begin
                    g1mem[off] = data;
                    sb.push_back('{modelSum(gbuf[off], data), {half, off}, cyc, lat_en});
                    if (int'(off) == LAST) last_g1_acc = cyc;
                end
                if (int'(off) == LAST) mstate = !mstate;
            end
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    // Hold the output stalled for five cycles with the next beat pending.
    task automatic doStall(input logic half, input int o, input int mode);
        out_rdy = 1'b0;
        in_info = {18'h0, half, 1'b1, 12'(o + 1)};
        in_data = g1Data(mode, o + 1);
        in_vld  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_rdy", in_rdy, 0);
            checkOutput("stall_out_vld", out_vld, 1);
            checkOutput("stall_hold_data", out_data, modelSum(gbuf[o - 1], g1mem[o - 1]));
            checkOutput("stall_hold_info", out_info, {half, 12'(o - 1)});
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        in_vld  = 1'b0;
    endtask

    // One full channel: every group 0 offset, then every group 1 offset.
    task automatic runChannel(input int mode, input logic half, input int stall_at, input int err_at);
        for (int o = 0; o <= LAST; o++) begin
            if (o == err_at) begin
                applyStimulus(1'b1, half, 12'(o), 32'h5555_5555);
                @(negedge clk);
                checkOutput("seq_err_set", seq_err, 1);
                checkOutput("no_out_on_err", out_vld, 0);
                @(posedge clk);
                #1;
            end
            applyStimulus(1'b0, half, 12'(o), g0Data(mode, o));
        end
        for (int o = 0; o <= LAST; o++) begin
            lat_en = (o != stall_at);
            applyStimulus(1'b1, half, 12'(o), g1Data(mode, o));
            lat_en = 1'b1;
            if (o == stall_at) doStall(half, o, mode);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare, latency and done-pulse tracking.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ch_done) begin
                ch_pulses++;
                checkOutput("ch_done_timing", 64'(cyc), 64'(last_g1_acc + 1));
            end
            if (all_done) begin
                all_pulses++;
                all_at = ch_pulses;
                checkOutput("all_done_with_ch", ch_done, 1);
            end
            if (out_vld) begin
                if (sb.size() == 0) begin
                    checkOutput("out_without_beat", out_vld, 0);
                end else begin
                    if (fresh && sb[0].lat) checkOutput("latency", 64'(cyc - sb[0].acc), 2);
                    if (out_rdy) begin
                        mon_e = sb.pop_front();
                        checkOutput("out_data", out_data, mon_e.data);
                        checkOutput("out_info", out_info, mon_e.info);
                    end
                end
            end
        end
        fresh = !out_vld || out_rdy;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_vld", out_vld, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_info", out_info, 0);
        checkOutput("rst_ch_done", ch_done, 0);
        checkOutput("rst_all_done", all_done, 0);
        checkOutput("rst_seq_err", seq_err, 0);
        checkOutput("rst_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] ramp channel with stall at offset 100");
        runChannel(0, 1'b0, 100, -1);
        checkOutput("ch_done_count_a", ch_pulses, 1);
        checkOutput("seq_err_clean", seq_err, 0);

        $display("[TB] wrong-group beat at offset 7");
        runChannel(1, 1'b1, -1, 7);
        checkOutput("seq_err_sticky", seq_err, 1);
        checkOutput("ch_done_count_b", ch_pulses, 2);

        $display("[TB] overflow channel");
        runChannel(2, 1'b0, -1, -1);
        checkOutput("ch_done_count_c", ch_pulses, 3);
        checkOutput("no_early_all_done", all_pulses, 0);

        $display("[TB] reset in the middle of group 1");
        for (int o = 0; o <= LAST; o++) applyStimulus(1'b0, 1'b1, 12'(o), $urandom());
        for (int o = 0; o < 10; o++) applyStimulus(1'b1, 1'b1, 12'(o), $urandom());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        mstate     = 1'b0;
        ch_pulses  = 0;
        all_pulses = 0;
        @(negedge clk);
        checkOutput("midrst_out_vld", out_vld, 0);
        checkOutput("midrst_seq_err", seq_err, 0);
        checkOutput("midrst_ch_done", ch_done, 0);
        @(posedge clk);
        #1;

        $display("[TB] 64 channel pairs");
        for (int c = 0; c < 64; c++) begin
            runChannel(1, c[0], -1, -1);
            if (c == 0) checkOutput("post_rst_channel", ch_pulses, 1);
        end
        checkOutput("ch_done_64", ch_pulses, 64);
        checkOutput("all_done_once", all_pulses, 1);
        checkOutput("all_done_at_64", all_at, 64);
        checkOutput("seq_err_after_64", seq_err, 0);

        $display("[TB] out-of-range offset");
        applyStimulus(1'b0, 1'b0, 12'd200, 32'h1234_5678);
        @(negedge clk);
        checkOutput("range_seq_err", seq_err, 1);
        checkOutput("range_no_out", out_vld, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
